prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the instruction memory and the single-cycle core. It accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit big-endian instruction words, and writes them into instruction memory starting at word 0. It holds the core in reset until a complete image has been written and its checksum has verified.

## Interface
Parameters:
- ADDR_W, 7, instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  packed instruction word.
- core_hold  out  1  held high while the core must stay in reset; drives the core's reset.
- done  out  1  image loaded and checksum verified.
- error  out  1  load aborted.

## Operation
- Stream format:
  - 2 bytes: word count N, big-endian.
  - N×4 bytes: instruction words, most significant byte first.
  - 1 byte: checksum, equal to the XOR of all 4N payload bytes.
- A byte transfers on a rising edge where in_valid and in_ready are both 1. No other byte is consumed.
- States:
  - IDLE: start → LEN_HI.
  - LEN_HI: on transfer, latch N[15:8] → LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. If N == 0 or N > 2^ADDR_W → ERROR; otherwise → DATA.
  - DATA: byte counter 0..3 shifts bytes into the word register and XORs each byte into the running checksum. On the 4th byte, issue a write. After word N → CHECK.
  - CHECK: on transfer, compare the byte with the running checksum. Equal → DONE; not equal → ERROR.
  - DONE / ERROR: terminal. start → LEN_HI, which clears the address, byte counter, checksum, done and error.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in IDLE, DONE and ERROR.
- core_hold = 0 only in DONE; 1 in every other state, including ERROR.
- start while in LEN_HI, LEN_LO, DATA or CHECK is ignored.
- Widths:
  - Word counter is ADDR_W+1 bits, so N = 2^ADDR_W fits.
  - imem_addr is ADDR_W bits. It is cleared on entering LEN_HI and incremented by 1 after each write. It never wraps, because N is bounded.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_hold 1, done 0, error 0, internal counters and checksum 0.
- Reset asserted mid-load aborts immediately to IDLE. Written memory contents are not cleared.
- Write latency:
  - imem_we pulses high for exactly one cycle, in the cycle after the edge that accepted the 4th byte of a word.
  - imem_addr and imem_wdata are stable in that cycle.
  - imem_addr increments on the edge that ends the pulse.
- in_ready remains 1 during the write cycle, so back-to-back bytes sustain one word per 4 cycles.
- DONE/ERROR entry:
  - done or error is registered and rises on the edge after the deciding byte.
  - core_hold falls on the same edge that done rises.
  - For N words this is exactly 4N+3 transfers after start.
- Stalls: in_valid = 0 holds all state. There is no timeout.

## Structure
- Package `loader_pkg` holds:
  - the state encoding constants (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - the length-field width (16);
  - the checksum width (8).
- Sub-module `word_packer`:
  - 8-bit to 32-bit big-endian shift register with a 2-bit byte counter;
  - emits a one-cycle word_valid;
  - has a synchronous clear, driven on LEN_HI entry.
- The top level holds the FSM, word counter, address register and checksum.

## Test plan
- Reset mid-DATA (after 6 bytes) → state IDLE, imem_we 0, core_hold 1, in_ready 0. A fresh start then reloads from address 0.
- Load N=2, words 0x20080005 and 0x00000000, checksum 0x2D, in_valid held high → imem_we at addresses 0 and 1 with those words, one word per 4 cycles. done rises after 11 transfers and core_hold falls on that same edge.
- Same image with in_valid toggled every other cycle → identical writes and result. No byte is lost or duplicated.
- Checksum byte 0x00 instead of 0x2D → error = 1, done = 0, core_hold stays 1. start then restarts cleanly.
- N=0 header, and N=129 with ADDR_W=7 → error = 1 right after LEN_LO, and no imem_we pulse.
- N=128 full-depth load → the last write is at address 127 with no wrap, and done rises.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants for the boot program loader
//
// Purpose: FSM state encoding and field widths used by prog_loader and
//          word_packer.
// Contents:
//   ST_*    3-bit FSM state constants
//   LEN_W   width of the word-count header field (bits)
//   CSUM_W  width of the trailing checksum byte (bits)
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - 8-bit to 32-bit big-endian word packer
//
// Purpose: shifts accepted bytes into a 32-bit word, MSB first, and flags
//          the cycle after the 4th byte with a one-cycle word_valid.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          synchronous clear of byte counter and word register
//   byte_valid   a byte is accepted this cycle
//   byte_data    the accepted byte
//   word_valid   one-cycle strobe, word_data holds a complete word
//   word_data    packed word (stable while word_valid is high)
//   byte_cnt     bytes already shifted into the current word (0..3)
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [1:0]  byte_cnt
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_valid) begin
      word_d  = {word_q[23:0], byte_data};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;
  assign word_data  = word_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time program loader into instruction memory
//
// Purpose: accepts a byte stream (16-bit word count N, 4N payload bytes,
//          XOR checksum byte), writes the packed words to imem from word 0
//          and releases the core only after the checksum verifies.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start                         begin a load (only in IDLE/DONE/ERROR)
//   in_valid, in_data, in_ready   byte stream handshake
//   imem_we, imem_addr, imem_wdata  instruction-memory write port
//   core_hold                     core reset, low only in DONE
//   done, error                   load outcome
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned       MAX_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CSUM_W-1:0] csum_q, csum_d;

  logic              xfer;
  logic              pk_clr;
  logic              pk_byte_valid;
  logic              pk_word_valid;
  logic [31:0]       pk_word_data;
  logic [1:0]        pk_byte_cnt;
  logic [LEN_W-1:0]  len_word;

  assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHECK);
  assign xfer          = in_valid && in_ready;
  assign pk_byte_valid = xfer && (state_q == ST_DATA);
  assign len_word      = {len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    target_d   = target_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    pk_clr     = 1'b0;

    // The final write leaves the address on the last word rather than
    // stepping past the top of memory.
    if (pk_word_valid && (word_cnt_q != target_q)) begin
      addr_d = addr_q + ADDR_ONE;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          addr_d     = '0;
          word_cnt_d = '0;
          csum_d     = '0;
          pk_clr     = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          target_d = len_word[ADDR_W:0];
          if ((len_word == '0) || (32'(len_word) > MAX_WORDS)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ in_data;
          if (pk_byte_cnt == 2'd3) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
            if ((word_cnt_q + CNT_ONE) == target_q) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= '0;
      target_q   <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      target_q   <= target_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
    end
  end

  word_packer u_word_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_byte_valid),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word_data  (pk_word_data),
    .byte_cnt   (pk_byte_cnt)
  );

  assign imem_we    = pk_word_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = pk_word_data;
  assign core_hold  = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  typedef struct {
    string name;
    int    hdr_n;
    int    nwords;
    int    csum_mode;   // 0 correct, 1 force 0x00, 2 correct^0x5A
    int    word_mode;   // 0 fixed pair, 1 random
    int    valid_mode;  // 0 always, 1 toggle, 2 random
    bit    exp_done;
    bit    exp_err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: write log, transfer count, transfer count when done rises.
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          cyc_cnt = 0;
  int          xfer_cnt = 0;
  int          xfer_at_done = -1;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (rst && imem_we) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
      got_cyc.push_back(cyc_cnt);
    end
    if (rst && in_valid && in_ready) xfer_cnt++;
    if (done && !done_prev && xfer_at_done < 0) xfer_at_done = xfer_cnt;
    done_prev = done;
  end

  task automatic clear_mon();
    got_addr = {};
    got_data = {};
    got_cyc = {};
    xfer_cnt = 0;
    xfer_at_done = -1;
  endtask

  function automatic bq_t build(input vec_t v);
    bq_t         s;
    logic [7:0]  x;
    logic [31:0] w;
    s = {};
    x = 8'h00;
    s.push_back(8'(v.hdr_n >> 8));
    s.push_back(8'(v.hdr_n));
    for (int i = 0; i < v.nwords; i++) begin
      if (v.word_mode == 0) w = (i == 0) ? 32'h20080005 : 32'h00000000;
      else w = $urandom;
      for (int b = 3; b >= 0; b--) begin
        s.push_back(w[b*8 +: 8]);
        x ^= w[b*8 +: 8];
      end
    end
    if (v.nwords > 0) begin
      if (v.csum_mode == 1) s.push_back(8'h00);
      else if (v.csum_mode == 2) s.push_back(x ^ 8'h5A);
      else s.push_back(x);
    end
    return s;
  endfunction

  // Reference: parse the stream by the format rules. outcome 1 done, 2 error.
  function automatic void model(input bq_t s, output int outcome, output wq_t words);
    int         n;
    logic [7:0] x;
    words = {};
    n = (int'(s[0]) << 8) | int'(s[1]);
    if (n == 0 || n > DEPTH) begin
      outcome = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      words.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      for (int b = 0; b < 4; b++) x ^= s[2+4*i+b];
    end
    outcome = (s[2+4*n] == x) ? 1 : 2;
  endfunction

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_stream(input bq_t s, input int mode, input string name);
    int   idx = 0;
    int   budget = 0;
    logic rdy;
    while (idx < s.size() && budget < 20000) begin
      if (mode == 0) in_valid = 1'b1;
      else if (mode == 1) in_valid = (budget % 2 == 0);
      else in_valid = 1'($urandom_range(0, 1));
      in_data = s[idx];
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (idx < s.size()) check({name, "_stream_timeout"}, longint'(idx), longint'(s.size()));
  endtask

  task automatic run_case(input vec_t v);
    bq_t s;
    wq_t exp_w;
    int  outcome;
    int  bad;
    s = build(v);
    model(s, outcome, exp_w);
    clear_mon();
    pulse_start();
    run_stream(s, v.valid_mode, v.name);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({v.name, "_model_outcome"}, longint'(outcome), v.exp_done ? 64'd1 : 64'd2);
    check({v.name, "_done"}, longint'(done), longint'(v.exp_done));
    check({v.name, "_error"}, longint'(error), longint'(v.exp_err));
    check({v.name, "_core_hold"}, longint'(core_hold), longint'(!v.exp_done));
    check({v.name, "_in_ready"}, longint'(in_ready), 64'd0);
    check({v.name, "_write_count"}, longint'(got_addr.size()), longint'(exp_w.size()));
    bad = 0;
    for (int i = 0; i < got_addr.size() && i < exp_w.size(); i++)
      if (got_addr[i] != i || got_data[i] != exp_w[i]) bad++;
    check({v.name, "_write_content_errs"}, longint'(bad), 64'd0);
    if (v.exp_done)
      check({v.name, "_xfers_at_done"}, longint'(xfer_at_done), longint'(4 * v.nwords + 3));
    if (v.valid_mode == 0 && got_cyc.size() >= 2) begin
      bad = 0;
      for (int i = 1; i < got_cyc.size(); i++)
        if (got_cyc[i] - got_cyc[i-1] != 4) bad++;
      check({v.name, "_write_spacing_errs"}, longint'(bad), 64'd0);
    end
    if (v.hdr_n == DEPTH && got_addr.size() > 0)
      check({v.name, "_last_addr"}, longint'(got_addr[got_addr.size()-1]), longint'(DEPTH - 1));
  endtask

  vec_t vecs[9];

  initial begin
    bq_t s;
    bq_t part;

    vecs[0] = '{"n2_full",    2,   2,   0, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{"n2_toggle",  2,   2,   0, 0, 1, 1'b1, 1'b0};
    vecs[2] = '{"n2_badsum",  2,   2,   1, 0, 0, 1'b0, 1'b1};
    vecs[3] = '{"n0",         0,   0,   0, 1, 0, 1'b0, 1'b1};
    vecs[4] = '{"n129",       129, 0,   0, 1, 0, 1'b0, 1'b1};
    vecs[5] = '{"n128_full",  128, 128, 0, 1, 2, 1'b1, 1'b0};
    vecs[6] = '{"n5_rand",    5,   5,   0, 1, 2, 1'b1, 1'b0};
    vecs[7] = '{"n1_full",    1,   1,   0, 1, 0, 1'b1, 1'b0};
    vecs[8] = '{"n3_randsum", 3,   3,   2, 1, 2, 1'b0, 1'b1};

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 64'd0);
    check("rst_imem_we", longint'(imem_we), 64'd0);
    check("rst_imem_addr", longint'(imem_addr), 64'd0);
    check("rst_imem_wdata", longint'(imem_wdata), 64'd0);
    check("rst_core_hold", longint'(core_hold), 64'd1);
    check("rst_done", longint'(done), 64'd0);
    check("rst_error", longint'(error), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_case(vecs[i]);

    // Restart after the checksum error run must still work.
    run_case(vecs[0]);

    // Reset mid-DATA after 6 bytes, with an ignored start in between.
    s = build(vecs[0]);
    part = {};
    for (int i = 0; i < 6; i++) part.push_back(s[i]);
    clear_mon();
    pulse_start();
    run_stream(part, 0, "mid_reset");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_ignored_addr", longint'(imem_addr), 64'd1);
    check("start_ignored_in_ready", longint'(in_ready), 64'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_reset_in_ready", longint'(in_ready), 64'd0);
    check("mid_reset_imem_we", longint'(imem_we), 64'd0);
    check("mid_reset_core_hold", longint'(core_hold), 64'd1);
    check("mid_reset_addr", longint'(imem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    run_case(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
